pos_cell_rd_ctrl: RTL
=====================

// Module: pos_cell_rd_ctrl
// PURPOSE
//  Sequencer/arbiter for one single-port cell position RAM (96b {posz,posy,posx}; addr 0 = particle count).
//  On rd_start: reads the count, then streams particles 1..count to force-evaluation with valid/last tags.
//  Shares the one RAM port with motion-update write-back; writes take priority and stall read issue.
//  Instantiated next to each cell RAM in the position cache.
// PARAMETERS
//  DATA_WIDTH    96   RAM word width
//  ADDR_WIDTH    8    RAM address width
//  PARTICLE_NUM  220  RAM depth; max particle count = PARTICLE_NUM-1
//  RD_LATENCY    2    RAM address-to-q delay in cycles (registered output)
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset: asynchronous, active-low
//  rd_start       in   1           pulse: begin streaming the cell
//  rd_busy        out  1           high from the cycle after rd_start is accepted until rd_done
//  rd_done        out  1           1-cycle pulse: stream complete
//  rd_count       out  ADDR_WIDTH  count captured from addr 0 (after clamping)
//  rd_err         out  1           count overflow flag; sticky until next accepted rd_start
//  rd_valid       out  1           rd_data holds one particle
//  rd_last        out  1           with rd_valid: final particle of the cell
//  rd_id          out  ADDR_WIDTH  RAM address of the particle on rd_data
//  rd_data        out  DATA_WIDTH  particle position (mem_q passed straight through)
//  wr_req         in   1           write-back request
//  wr_addr        in   ADDR_WIDTH  write address (0 = count)
//  wr_data        in   DATA_WIDTH  write data
//  wr_gnt         out  1           combinational; equals wr_req
//  mem_address    out  ADDR_WIDTH  to RAM
//  mem_data       out  DATA_WIDTH  to RAM (equals wr_data)
//  mem_rden       out  1           to RAM
//  mem_wren       out  1           to RAM
//  mem_q          in   DATA_WIDTH  from RAM
// BEHAVIOUR
//  Reset: state IDLE; all tag pipelines, counters, rd_* flags and rd_count = 0.
//   Outputs are 0 except wr_gnt/mem_* when wr_req is high.
//  mem_* signals are combinational from state and wr_*; no extra register, so RAM latency stays RD_LATENCY.
//  Write priority: wr_req=1 -> mem_wren=1, mem_address=wr_addr, mem_rden=0.
//   Any read issue scheduled for that cycle slips one cycle; the address counter holds.
//  FSM:
//   IDLE: rd_start=1 -> RD_CNT. rd_start in any other state is ignored.
//   RD_CNT: issue addr 0 (rden=1) when no write is pending -> WAIT_CNT.
//   WAIT_CNT: wait RD_LATENCY cycles from issue, then capture cnt=mem_q[ADDR_WIDTH-1:0].
//    If cnt > PARTICLE_NUM-1: clamp to PARTICLE_NUM-1 and set rd_err.
//    cnt=0 -> DONE; otherwise -> STREAM with addr=1.
//   STREAM: issue addr each non-write cycle, addr++. After issuing addr==cnt -> DRAIN.
//   DRAIN: wait until the tag pipeline is empty -> DONE.
//   DONE: rd_done=1 for one cycle, rd_busy=0 -> IDLE.
//  Tag pipeline: RD_LATENCY-deep shift of {vld, last, id}.
//   Loaded when a particle read issues (not for the addr-0 read).
//   rd_valid/rd_last/rd_id come from the pipeline tail, aligned with mem_q.
//  Throughput: one particle per cycle with no writes.
//   Uncontended latency: rd_start at T -> addr0 issue T+1 -> count at T+3 -> addr1 issue T+4 -> first rd_valid T+6.
//  Write to addr 0 during a stream: does not affect the stream; the captured count is used.
//  Writes to particle addresses not yet issued are seen by the stream (single-port ordering).
//  Async reset mid-stream: pipeline cleared; no rd_valid or rd_done until the next rd_start.
// TESTING
//  1. RAM addr0=3, addr1..3=A,B,C, rd_start@T -> rd_valid T+6..T+8, ids 1,2,3, data A,B,C; rd_last@T+8; rd_done@T+9.
//  2. addr0=0 -> no rd_valid, rd_done@T+4, rd_count=0, rd_err=0.
//  3. addr0=250 (PARTICLE_NUM=220) -> rd_count=219, rd_err=1, 219 valid beats, last id=219.
//  4. Case 1 with wr_req held at T+5 for 2 cycles -> mem_wren at T+5,T+6; ids still 1,2,3 with no gaps in order; valid beats at T+6,T+9,T+10.
//  5. rd_start pulsed again while busy -> ignored; exactly one stream and one rd_done.
//  6. rst_n low at T+7 in case 1 -> all outputs 0 immediately; no further rd_valid or rd_done until a new rd_start.

Source files
------------

// File: rtl/pos_cell_rd_ctrl.sv
// Read sequencer for one cell position RAM: fetches the particle count from addr 0,
// then streams particles 1..count, sharing the single RAM port with write-back (writes win).
module pos_cell_rd_ctrl #(
  parameter int unsigned DATA_WIDTH   = 96,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PARTICLE_NUM = 220,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] rd_count,
  output logic                  rd_err,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [ADDR_WIDTH-1:0] rd_id,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int unsigned WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [WAIT_W-1:0]     WAIT_END = WAIT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                  vld;
    logic                  last;
    logic [ADDR_WIDTH-1:0] id;
  } tag_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [WAIT_W-1:0]     wait_q;
  tag_t                  pipe [RD_LATENCY];

  logic                  cnt_issue;
  logic                  part_issue;
  logic                  pipe_head_busy;
  logic [ADDR_WIDTH-1:0] mem_cnt;
  logic                  cnt_over;
  logic [ADDR_WIDTH-1:0] cnt_clamped;

  // RAM port arbitration: a pending write steals the cycle and the read slips
  always_comb begin
    cnt_issue   = 1'b0;
    part_issue  = 1'b0;
    mem_address = '0;
    if (!wr_req) begin
      cnt_issue  = (state == RD_CNT);
      part_issue = (state == STREAM);
    end
    if (wr_req) begin
      mem_address = wr_addr;
    end else if (part_issue) begin
      mem_address = addr_q;
    end
    mem_wren = wr_req;
    mem_rden = cnt_issue | part_issue;
    mem_data = wr_data;
    wr_gnt   = wr_req;
  end

  // True while any tag other than the tail is still in flight
  always_comb begin
    pipe_head_busy = 1'b0;
    for (int i = 0; i < int'(RD_LATENCY) - 1; i++) begin
      pipe_head_busy = pipe_head_busy | pipe[i].vld;
    end
  end

  always_comb begin
    mem_cnt     = mem_q[ADDR_WIDTH-1:0];
    cnt_over    = (mem_cnt > MAX_CNT);
    cnt_clamped = cnt_over ? MAX_CNT : mem_cnt;
  end

  assign rd_valid = pipe[RD_LATENCY-1].vld;
  assign rd_last  = pipe[RD_LATENCY-1].last;
  assign rd_id    = pipe[RD_LATENCY-1].id;
  assign rd_data  = mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      rd_busy  <= 1'b0;
      rd_done  <= 1'b0;
      rd_count <= '0;
      rd_err   <= 1'b0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        pipe[i] <= '0;
      end
    end else begin
      rd_done <= 1'b0;

      // Tag travels alongside the RAM read so it lands with mem_q
      pipe[0].vld  <= part_issue;
      pipe[0].last <= part_issue && (addr_q == cnt_q);
      pipe[0].id   <= part_issue ? addr_q : '0;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe[i] <= pipe[i-1];
      end

      case (state)
        IDLE: begin
          if (rd_start) begin
            state   <= RD_CNT;
            rd_busy <= 1'b1;
            rd_err  <= 1'b0;
          end
        end
        RD_CNT: begin
          if (cnt_issue) begin
            state  <= WAIT_CNT;
            wait_q <= '0;
          end
        end
        WAIT_CNT: begin
          if (wait_q == WAIT_END) begin
            rd_count <= cnt_clamped;
            cnt_q    <= cnt_clamped;
            addr_q   <= ADDR_WIDTH'(1);
            if (cnt_over) begin
              rd_err <= 1'b1;
            end
            if (cnt_clamped == '0) begin
              state   <= DONE;
              rd_busy <= 1'b0;
              rd_done <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        STREAM: begin
          if (part_issue) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (addr_q == cnt_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!pipe_head_busy) begin
            state   <= DONE;
            rd_busy <= 1'b0;
            rd_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
